pcie_ingress: RTL and testbench
===============================

# pcie_ingress

Ingress stage placed directly upstream of the PCIe transaction block's main FIFO. It accepts 6-bit words from a traffic source with a valid/ready handshake, holds them in a 2-entry skid buffer, and drives the main FIFO's `push` and `data_in_principal` only while the main FIFO's `Pausa_MF` is deasserted. It also gates traffic during `init` and, optionally, counts forwarded words per virtual channel.

## Interface
Parameters:
- `DATA_W`, 6: word width. Bit 5 is vc_id, bit 4 is destination, bits 3:0 are payload.
- `CNT_W`, 8: width of each per-VC counter.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset_L`  in  1  asynchronous, active-low reset.
- `init`  in  1  same init strobe the control FSM receives; forces the INIT state.
- `in_data`  in  DATA_W  word from the source.
- `in_valid`  in  1  source word valid.
- `in_ready`  out  1  block can accept a word this cycle.
- `Pausa_MF`  in  1  main FIFO pause (almost-full) flag.
- `push`  out  1  push strobe to the main FIFO (registered).
- `data_out`  out  DATA_W  word to the main FIFO `data_in_principal` (registered).
- `busy`  out  1  skid buffer non-empty or `push` high.
- `cnt_vc0`, `cnt_vc1`  out  CNT_W each  forwarded-word counts per VC (present only under `PCIE_INGRESS_CNT_EN`).

## Operation
- Reset (`reset_L`=0, asynchronous): state=INIT, buffer empty, `push`=0, `data_out`=0, `in_ready`=0, `busy`=0, pausa_q=0, counters=0.
- States:
  - INIT: `in_ready`=0, no push; buffer flushed; counters cleared. Leaves to IDLE on the first edge with `init`=0.
  - IDLE: buffer empty; `in_ready`=1. Moves to ACTIVE on accept.
  - ACTIVE: buffer non-empty and pausa_q=0 -> issue head. Moves to STALL when pausa_q=1 and to IDLE when the buffer drains.
  - STALL: pausa_q=1; no push, and accepts continue while the buffer has space. Moves to ACTIVE when pausa_q=0, or to IDLE if the buffer is empty.
- `init`=1 in any state -> INIT on the next edge; this has priority over every other transition.
- Accept: `in_valid` & `in_ready` at an edge writes `in_data` to the buffer tail.
- `in_ready` = (occupancy < 2) & state≠INIT (combinational from registered occupancy and state).
- Issue: at an edge with occupancy > 0, pausa_q=0 and state≠INIT, set `push`<=1, set `data_out`<=head, pop the head. Otherwise `push`<=0 and `data_out` holds its value.
- Simultaneous accept and issue in the same cycle is legal; occupancy is unchanged.
- pausa_q is `Pausa_MF` registered once. Issue decisions use pausa_q only.
- Ordering is strictly FIFO; words are never dropped or reordered.

## Timing
- Latency: a word accepted at edge k appears with `push`=1 after edge k+1 when unpaused and the buffer is otherwise empty.
- Sustained throughput is 1 word/cycle with both occupancy slots used.
- Pause reaction: `Pausa_MF` rising before edge j allows at most one further push (the one issued at edge j). Pushes stop from edge j+1. The main FIFO threshold must absorb this word.
- Resume: `Pausa_MF` falling before edge m gives the first push at edge m+1.
- Buffer full (occupancy=2): `in_ready`=0. `in_valid` held by the source keeps its word, with no loss.
- `init` asserted mid-stream: buffered words are discarded and `push` is 0 from the next edge.
- `reset_L` asserted mid-stream: outputs go to their reset values immediately, without waiting for a clock edge.

## Configuration
- `PCIE_INGRESS_CNT_EN` defined: `cnt_vc0` and `cnt_vc1` exist.
  - Each increments by 1 on every issued word with vc_id (bit 5) = 0 or 1 respectively.
  - Counters wrap from 2^CNT_W−1 to 0.
  - Counters are cleared by reset or INIT.
- Not defined: counter ports and logic are absent; all other behaviour is identical.

## Structure
- Shared package/header holds:
  - state encodings INIT=2'd0, IDLE=2'd1, ACTIVE=2'd2, STALL=2'd3;
  - field positions VC_BIT=5, DEST_BIT=4;
  - DATA_W.
- One sub-module is natural: `skid_buf2`, a 2-entry FIFO with write/read/occupancy, asynchronous active-low reset, that fits in the single-cycle bypass-free path.

## Test plan
- Reset then `init`=1 for 3 cycles, release: `in_ready`=0 during init, 1 one cycle after release; `push`=0 throughout.
- Stream 0x21,0x05,0x30 back-to-back, `Pausa_MF`=0: `push`=1 for 3 consecutive cycles starting edge k+1 with `data_out` 0x21,0x05,0x30. With the macro, final `cnt_vc1`=2 and `cnt_vc0`=1.
- Continuous `in_valid`, `Pausa_MF` raised at cycle 4 for 5 cycles: exactly one push after the rise, then none. Buffer fills to 2 and `in_ready`=0. Resume yields the remaining words in order with no loss.
- Accept and issue in the same cycle with occupancy 1: occupancy stays 1, and words emerge in the order of acceptance.
- `init` pulsed with 2 words buffered: no push follows, buffer is empty after INIT, and counters read 0.
- Drive 256 VC0 words with the macro enabled: `cnt_vc0` wraps to 0.

Source files
------------

// File: rtl/pcie_ingress_pkg.sv
// Shared definitions for the PCIe ingress stage: word field positions,
// skid-buffer geometry and the control state encoding.
package pcie_ingress_pkg;

  localparam int unsigned DATA_W   = 6;
  localparam int unsigned VC_BIT   = 5;
  localparam int unsigned DEST_BIT = 4;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned OCC_W = 2;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_STALL  = 2'd3
  } state_e;

endpackage

// File: rtl/pcie_ingress_skid_buf2.sv
// skid_buf2: 2-entry FIFO with write/read/occupancy and synchronous flush.
// The head is read combinationally; a write never bypasses to the head.
module pcie_ingress_skid_buf2
  import pcie_ingress_pkg::*;
#(
  parameter int unsigned W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             wr_en_i,
  input  logic [W-1:0]     wr_data_i,
  input  logic             rd_en_i,
  output logic [W-1:0]     rd_data_o,
  output logic [OCC_W-1:0] occ_o
);

  logic [W-1:0]     mem_q [DEPTH];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;
  logic             wr_c;
  logic             rd_c;

  // A write into a full buffer is only taken when the head leaves in the same cycle.
  assign rd_c  = rd_en_i & (occ_q != '0);
  assign wr_c  = wr_en_i & ((occ_q != OCC_W'(DEPTH)) | rd_c);
  assign occ_d = occ_q + OCC_W'(wr_c) - OCC_W'(rd_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= '0;
    end else begin
      if (wr_c) begin
        mem_q[wr_ptr_q] <= wr_data_i;
      end
      wr_ptr_q <= wr_ptr_q ^ wr_c;
      rd_ptr_q <= rd_ptr_q ^ rd_c;
      occ_q    <= occ_d;
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign occ_o     = occ_q;

endmodule

// File: rtl/pcie_ingress.sv
// Ingress stage ahead of the PCIe main FIFO: skid-buffers source words and
// pushes them while Pausa_MF is low. PCIE_INGRESS_CNT_EN adds per-VC counters.
module pcie_ingress #(
  parameter int unsigned DATA_W = 6
`ifdef PCIE_INGRESS_CNT_EN
  ,
  parameter int unsigned CNT_W  = 8
`endif
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              init,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              Pausa_MF,
  output logic              push,
  output logic [DATA_W-1:0] data_out,
  output logic              busy
`ifdef PCIE_INGRESS_CNT_EN
  ,
  output logic [CNT_W-1:0]  cnt_vc0,
  output logic [CNT_W-1:0]  cnt_vc1
`endif
);

  import pcie_ingress_pkg::*;

  state_e            state_q;
  state_e            state_d;
  logic              pausa_q;
  logic              push_q;
  logic              push_d;
  logic [DATA_W-1:0] data_out_q;
  logic [DATA_W-1:0] data_out_d;
  logic [OCC_W-1:0]  occ;
  logic [OCC_W-1:0]  occ_nxt;
  logic [DATA_W-1:0] head;
  logic              flush_c;
  logic              accept_c;
  logic              wr_en_c;
  logic              issue_c;

  // init flushes immediately, so a word handshaken on an init edge is discarded.
  assign in_ready = (occ < OCC_W'(DEPTH)) && (state_q != ST_INIT);
  assign accept_c = in_valid & in_ready;
  assign flush_c  = init | (state_q == ST_INIT);
  assign wr_en_c  = accept_c & ~flush_c;
  assign issue_c  = (occ != '0) & ~pausa_q & ~flush_c;
  assign occ_nxt  = flush_c ? '0 : occ + OCC_W'(wr_en_c) - OCC_W'(issue_c);

  pcie_ingress_skid_buf2 #(
    .W (DATA_W)
  ) u_skid_buf2 (
    .clk       (clk),
    .rst_n     (reset_L),
    .flush_i   (flush_c),
    .wr_en_i   (wr_en_c),
    .wr_data_i (in_data),
    .rd_en_i   (issue_c),
    .rd_data_o (head),
    .occ_o     (occ)
  );

  // Next state and registered push/data_out.
  always_comb begin
    state_d    = state_q;
    push_d     = 1'b0;
    data_out_d = data_out_q;
    if (issue_c) begin
      push_d     = 1'b1;
      data_out_d = head;
    end
    if (init) begin
      state_d = ST_INIT;
    end else begin
      case (state_q)
        ST_INIT:   state_d = ST_IDLE;
        ST_IDLE:   if (accept_c) state_d = ST_ACTIVE;
        ST_ACTIVE: begin
          if (occ_nxt == '0)  state_d = ST_IDLE;
          else if (pausa_q)   state_d = ST_STALL;
        end
        ST_STALL: begin
          if (occ_nxt == '0)  state_d = ST_IDLE;
          else if (!pausa_q)  state_d = ST_ACTIVE;
        end
        default:   state_d = ST_INIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q    <= ST_INIT;
      pausa_q    <= 1'b0;
      push_q     <= 1'b0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      pausa_q    <= Pausa_MF;
      push_q     <= push_d;
      data_out_q <= data_out_d;
    end
  end

  assign push     = push_q;
  assign data_out = data_out_q;
  assign busy     = (occ != '0) | push_q;

`ifdef PCIE_INGRESS_CNT_EN
  logic [CNT_W-1:0] cnt_vc0_q;
  logic [CNT_W-1:0] cnt_vc0_d;
  logic [CNT_W-1:0] cnt_vc1_q;
  logic [CNT_W-1:0] cnt_vc1_d;

  // Forwarded-word counters, wrapping, cleared whenever the buffer is flushed.
  always_comb begin
    cnt_vc0_d = cnt_vc0_q;
    cnt_vc1_d = cnt_vc1_q;
    if (flush_c) begin
      cnt_vc0_d = '0;
      cnt_vc1_d = '0;
    end else if (issue_c) begin
      if (head[VC_BIT]) cnt_vc1_d = cnt_vc1_q + CNT_W'(1);
      else              cnt_vc0_d = cnt_vc0_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      cnt_vc0_q <= '0;
      cnt_vc1_q <= '0;
    end else begin
      cnt_vc0_q <= cnt_vc0_d;
      cnt_vc1_q <= cnt_vc1_d;
    end
  end

  assign cnt_vc0 = cnt_vc0_q;
  assign cnt_vc1 = cnt_vc1_q;
`endif

endmodule

// File: tb/tb_pcie_ingress.sv
// Scoreboard bench for pcie_ingress: accepted words are queued and matched
// against every push; directed checks cover latency, pause, init and reset.
module tb_pcie_ingress;

  localparam int unsigned DW = 6;

  logic          clk = 1'b0;
  logic          reset_L;
  logic          init;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          Pausa_MF;
  logic          push;
  logic [DW-1:0] data_out;
  logic          busy;
`ifdef PCIE_INGRESS_CNT_EN
  logic [7:0]    cnt_vc0;
  logic [7:0]    cnt_vc1;
`endif

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] sb_q [$];
  logic [DW-1:0] exp_w;
  logic [7:0]    mdl_vc0 = '0;
  logic [7:0]    mdl_vc1 = '0;
  int            pp;
  logic          will;

  always #5 clk = ~clk;

  pcie_ingress dut (
    .clk      (clk),
    .reset_L  (reset_L),
    .init     (init),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .Pausa_MF (Pausa_MF),
    .push     (push),
    .data_out (data_out),
    .busy     (busy)
`ifdef PCIE_INGRESS_CNT_EN
    ,
    .cnt_vc0  (cnt_vc0),
    .cnt_vc1  (cnt_vc1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic stream(input int n, input logic vc);
    int  sent;
    int  guard;
    logic acc;
    sent     = 0;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = {vc, 5'(sent)};
    while (sent < n && guard < n + 64) begin
      acc = in_valid && in_ready;
      tick();
      guard++;
      if (acc) begin
        sent++;
        in_data = {vc, 5'(sent)};
      end
    end
    chk("stream_done", 32'(sent), 32'(n));
    in_valid = 1'b0;
  endtask

  task automatic chk_cnt(input string tag, input int e0, input int e1);
`ifdef PCIE_INGRESS_CNT_EN
    chk({tag, "_vc0"}, 32'(cnt_vc0), 32'(e0));
    chk({tag, "_vc1"}, 32'(cnt_vc1), 32'(e1));
    chk({tag, "_mdl0"}, 32'(cnt_vc0), 32'(mdl_vc0));
    chk({tag, "_mdl1"}, 32'(cnt_vc1), 32'(mdl_vc1));
`else
    if (e0 < 0 || e1 < 0) $display("negative count request %s", tag);
`endif
  endtask

  // Scoreboard: queue words on accept, match against data_out on each push.
  always @(posedge clk) begin
    if (!reset_L || init) begin
      sb_q.delete();
      mdl_vc0 = '0;
      mdl_vc1 = '0;
    end else if (in_valid && in_ready) begin
      sb_q.push_back(in_data);
    end
    #1;
    if (push) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        exp_w = sb_q.pop_front();
        chk("sb_data", 32'(data_out), 32'(exp_w));
        if (exp_w[5]) mdl_vc1 = mdl_vc1 + 8'd1;
        else          mdl_vc0 = mdl_vc0 + 8'd1;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_L  = 1'b1;
    init     = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    Pausa_MF = 1'b0;
    #2 reset_L = 1'b0;
    #1;
    chk("rst_rdy",  32'(in_ready), 0);
    chk("rst_push", 32'(push), 0);
    chk("rst_dout", 32'(data_out), 0);
    chk("rst_busy", 32'(busy), 0);
    chk_cnt("rst_cnt", 0, 0);
    tick();
    tick();

    // init held for three edges after reset release
    reset_L = 1'b1;
    init    = 1'b1;
    repeat (3) begin
      tick();
      chk("init_rdy",  32'(in_ready), 0);
      chk("init_push", 32'(push), 0);
    end
    init = 1'b0;
    tick();
    chk("rdy_after_init", 32'(in_ready), 1);
    chk("push_after_init", 32'(push), 0);

    // back-to-back stream, unpaused
    in_valid = 1'b1;
    in_data  = 6'h21;
    tick();
    chk("lat_k", 32'(push), 0);
    in_data = 6'h05;
    tick();
    chk("lat_k1", 32'(push), 1);
    chk("str_d0", 32'(data_out), 32'h21);
    in_data = 6'h30;
    tick();
    chk("str_p1", 32'(push), 1);
    chk("str_d1", 32'(data_out), 32'h05);
    in_valid = 1'b0;
    tick();
    chk("str_p2", 32'(push), 1);
    chk("str_d2", 32'(data_out), 32'h30);
    tick();
    chk("str_end", 32'(push), 0);
    chk("str_hold", 32'(data_out), 32'h30);
    chk_cnt("str_cnt", 1, 2);

    // continuous source with Pausa_MF high for five edges
    pp       = 0;
    in_valid = 1'b1;
    in_data  = 6'h10;
    for (int c = 0; c < 16; c++) begin
      if (c == 4) Pausa_MF = 1'b1;
      if (c == 9) Pausa_MF = 1'b0;
      if (c == 8) begin
        chk("full_rdy",  32'(in_ready), 0);
        chk("full_busy", 32'(busy), 1);
      end
      will = in_valid && in_ready;
      tick();
      if (c >= 4 && c <= 9) pp += int'(push);
      if (c == 10) chk("resume_push", 32'(push), 1);
      if (will) in_data = in_data + 6'd1;
    end
    chk("pause_pushes", 32'(pp), 1);
    in_valid = 1'b0;
    repeat (4) tick();
    chk("drain_q", 32'(sb_q.size()), 0);
    chk("drain_push", 32'(push), 0);

    // accept and issue on the same edge with one word buffered
    Pausa_MF = 1'b1;
    tick();
    tick();
    in_valid = 1'b1;
    in_data  = 6'h1A;
    tick();
    chk("ai_hold", 32'(push), 0);
    in_valid = 1'b0;
    Pausa_MF = 1'b0;
    tick();
    chk("ai_wait", 32'(push), 0);
    in_valid = 1'b1;
    in_data  = 6'h07;
    tick();
    chk("ai_push", 32'(push), 1);
    chk("ai_dout", 32'(data_out), 32'h1A);
    chk("ai_rdy",  32'(in_ready), 1);
    chk("ai_busy", 32'(busy), 1);
    in_valid = 1'b0;
    tick();
    chk("ai_push2", 32'(push), 1);
    chk("ai_dout2", 32'(data_out), 32'h07);
    tick();
    chk("ai_idle", 32'(busy), 0);

    // init pulse with two words buffered
    Pausa_MF = 1'b1;
    tick();
    tick();
    in_valid = 1'b1;
    in_data  = 6'h2B;
    tick();
    in_data = 6'h0C;
    tick();
    in_valid = 1'b0;
    chk("ib_full", 32'(in_ready), 0);
    init = 1'b1;
    tick();
    chk("ini_push", 32'(push), 0);
    chk("ini_rdy",  32'(in_ready), 0);
    init     = 1'b0;
    Pausa_MF = 1'b0;
    pp       = 0;
    repeat (4) begin
      tick();
      pp += int'(push);
    end
    chk("ini_nopush", 32'(pp), 0);
    chk("ini_busy",   32'(busy), 0);
    chk("ini_rdy2",   32'(in_ready), 1);
    chk_cnt("ini_cnt", 0, 0);

    // VC0 counter up to its maximum, then wrap
    stream(255, 1'b0);
    repeat (4) tick();
    chk_cnt("wrap_255", 255, 0);
    stream(1, 1'b0);
    repeat (4) tick();
    chk_cnt("wrap_0", 0, 0);

    // asynchronous reset in the middle of a push
    in_valid = 1'b1;
    in_data  = 6'h2A;
    tick();
    tick();
    chk("pre_rst_push", 32'(push), 1);
    chk("pre_rst_dout", 32'(data_out), 32'h2A);
    #3 reset_L = 1'b0;
    #1;
    chk("arst_push", 32'(push), 0);
    chk("arst_dout", 32'(data_out), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_rdy",  32'(in_ready), 0);
    chk_cnt("arst_cnt", 0, 0);
    in_valid = 1'b0;
    tick();
    reset_L = 1'b1;
    tick();
    tick();
    chk("post_rst_push", 32'(push), 0);
    chk("post_rst_rdy",  32'(in_ready), 1);
    chk("sb_final", 32'(sb_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
